id_ex_skid_reg: RTL and testbench

Parametrised ID/EX pipeline register with a valid/ready handshake, a one-entry skid buffer, flush, and bubble insertion. It sits between the decode and execute stages. It replaces the fixed-width, always-advancing ID/EX register with one that can stall without losing data and can be squashed on a branch. It also keeps a saturating bubble counter for performance monitoring.

---
 rtl/id_ex_skid_reg.sv | 130 +++++++++++++
 tb/tb_id_ex_skid_reg.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - ID/EX pipeline register with valid/ready handshake, skid entry, flush and bubble counter
module id_ex_skid_reg #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int PC_W   = 8,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data1_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [ADDR_W-1:0] src_addr_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data1_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [ADDR_W-1:0] src_addr_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int PKT_W = CTRL_W + 2*DATA_W + 2*ADDR_W + PC_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_in_ready;
    logic [PKT_W-1:0]   r_main;
    logic [PKT_W-1:0]   r_skid;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic               w_main_valid;
    logic               w_accept;
    logic               w_pop;
    logic               w_load_main_in;
    logic               w_load_main_skid;
    logic               w_load_skid;
    logic [PKT_W-1:0]   w_pkt_in;
    logic [CTRL_W-1:0]  w_main_ctrl;

    assign w_pkt_in     = {ctrl_in, data1_in, imm_in, src_addr_in, wr_addr_in, pc_in};
    assign w_main_valid = (r_state != S_EMPTY);
    assign w_accept     = in_valid && r_in_ready;
    assign w_pop        = w_main_valid && out_ready;

    always_comb begin
        w_state_nx       = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nx     = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_pop && w_accept) begin
                    w_load_main_in = 1'b1;
                end else if (w_pop) begin
                    w_state_nx = S_EMPTY;
                end else if (w_accept) begin
                    w_state_nx  = S_TWO;
                    w_load_skid = 1'b1;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_state_nx       = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nx = S_EMPTY;
        endcase
        // Squash wins: held and incoming instructions are dropped, data regs keep stale values
        if (flush) begin
            w_state_nx       = S_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_EMPTY;
            r_in_ready   <= 1'b1;
            r_main       <= '0;
            r_skid       <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_in_ready <= (w_state_nx != S_TWO);
            if (w_load_main_in) begin
                r_main <= w_pkt_in;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_pkt_in;
            end
            if (!w_main_valid && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign {w_main_ctrl, data1_out, imm_out, src_addr_out, wr_addr_out, pc_out} = r_main;

    assign in_ready   = r_in_ready;
    assign out_valid  = w_main_valid;
    assign ctrl_out   = w_main_valid ? w_main_ctrl : '0;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb/tb_id_ex_skid_reg.sv - directed self-checking bench for id_ex_skid_reg
module tb_id_ex_skid_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [4:0] ctrl_in;
    logic [7:0] data1_in;
    logic [7:0] imm_in;
    logic [2:0] src_addr_in;
    logic [2:0] wr_addr_in;
    logic [7:0] pc_in;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] ctrl_out;
    logic [7:0] data1_out;
    logic [7:0] imm_out;
    logic [2:0] src_addr_out;
    logic [2:0] wr_addr_out;
    logic [7:0] pc_out;
    logic [3:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_skid_reg #(
        .DATA_W(8), .ADDR_W(3), .PC_W(8), .CTRL_W(5), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .ctrl_in(ctrl_in), .data1_in(data1_in), .imm_in(imm_in),
        .src_addr_in(src_addr_in), .wr_addr_in(wr_addr_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .data1_out(data1_out), .imm_out(imm_out),
        .src_addr_out(src_addr_out), .wr_addr_out(wr_addr_out), .pc_out(pc_out),
        .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ctrl_in = 5'b0; data1_in = 8'h0; imm_in = 8'h0;
        src_addr_in = 3'd0; wr_addr_in = 3'd0; pc_in = 8'h0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_ctrl", 32'(ctrl_out), 32'd0);

        // Streaming: one per cycle, skid unused
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            pc_in = 8'(i); ctrl_in = 5'b00001; data1_in = 8'(8'hA0 + i);
            imm_in = 8'(8'h50 + i); src_addr_in = 3'(i); wr_addr_in = 3'(7 - i);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc", 32'(pc_out), 32'(i));
        end
        chk("stream_data1", 32'(data1_out), 32'hA9);
        chk("stream_imm", 32'(imm_out), 32'h59);
        chk("stream_src", 32'(src_addr_out), 32'd1);
        chk("stream_wr", 32'(wr_addr_out), 32'd6);
        chk("stream_ctrl", 32'(ctrl_out), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("stream_bubble", 32'(bubble_cnt), 32'd1);

        // Stall and skid
        out_ready = 1'b0; in_valid = 1'b1; pc_in = 8'h10;
        tick();
        chk("stall_pc10", 32'(pc_out), 32'h10);
        pc_in = 8'h11;
        chk("stall_rdy_before", 32'(in_ready), 32'd1);
        tick();
        chk("stall_rdy_two", 32'(in_ready), 32'd0);
        chk("stall_hold10", 32'(pc_out), 32'h10);
        pc_in = 8'h12;
        tick();
        chk("stall_held_off", 32'(in_ready), 32'd0);
        chk("stall_still10", 32'(pc_out), 32'h10);
        out_ready = 1'b1;
        tick();
        chk("skid_pc11", 32'(pc_out), 32'h11);
        chk("skid_valid11", 32'(out_valid), 32'd1);
        chk("skid_rdy_back", 32'(in_ready), 32'd1);
        tick();
        chk("skid_pc12", 32'(pc_out), 32'h12);
        in_valid = 1'b0;
        tick();
        chk("skid_empty", 32'(out_valid), 32'd0);
        chk("skid_bubble", 32'(bubble_cnt), 32'd2);

        // Flush in TWO with in_valid=1
        out_ready = 1'b0; in_valid = 1'b1; pc_in = 8'h20; ctrl_in = 5'b10101;
        tick();
        pc_in = 8'h21;
        tick();
        chk("fl2_rdy", 32'(in_ready), 32'd0);
        flush = 1'b1; pc_in = 8'h22;
        tick();
        chk("fl2_valid", 32'(out_valid), 32'd0);
        chk("fl2_ctrl", 32'(ctrl_out), 32'd0);
        chk("fl2_rdy_after", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl2_no_emerge", 32'(out_valid), 32'd0);
        chk("fl2_bubble", 32'(bubble_cnt), 32'd4);

        // Flush in ONE while accepting: incoming discarded
        in_valid = 1'b1; pc_in = 8'h30;
        tick();
        flush = 1'b1; pc_in = 8'h31;
        tick();
        chk("fl1_valid", 32'(out_valid), 32'd0);
        chk("fl1_rdy", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl1_no_emerge", 32'(out_valid), 32'd0);
        chk("fl1_bubble", 32'(bubble_cnt), 32'd6);

        // Bubble gating, then saturation at 4'hF
        ctrl_in = 5'b11111;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("gate_ctrl", 32'(ctrl_out), 32'd0);
            chk("gate_bubble", 32'(bubble_cnt), 32'(6 + k));
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat_bubble", 32'(bubble_cnt), (9 + k > 15) ? 32'd15 : 32'(9 + k));
        end

        // Reset with flush while in TWO
        in_valid = 1'b1; out_ready = 1'b0; pc_in = 8'h40; data1_in = 8'hAA;
        tick();
        pc_in = 8'h41;
        tick();
        chk("rst2_two", 32'(in_ready), 32'd0);
        reset = 1'b0; flush = 1'b1; in_valid = 1'b0;
        tick();
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_ctrl", 32'(ctrl_out), 32'd0);
        chk("rst2_pc", 32'(pc_out), 32'd0);
        chk("rst2_data1", 32'(data1_out), 32'd0);
        chk("rst2_bubble", 32'(bubble_cnt), 32'd0);
        chk("rst2_rdy", 32'(in_ready), 32'd1);
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        tick();
        chk("rst2_no_replay", 32'(out_valid), 32'd0);
        chk("rst2_bubble1", 32'(bubble_cnt), 32'd1);
        tick();
        chk("rst2_no_replay2", 32'(out_valid), 32'd0);
        chk("rst2_pc_after", 32'(pc_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
